mips_bus_port: RTL and testbench
================================

Name: mips_bus_port

Overview:
Parametrised Avalon-MM master front-end for the multicycle MIPS core. It arbitrates between NUM_REQ core-side requesters, such as instruction fetch and load/store. It also handles byte-lane steering and sign or zero extension for byte, halfword and word accesses, the waitrequest stall, and misalignment and timeout errors. It replaces the core's direct drive of the Avalon address, read, write, byteenable and writedata signals.

Parameters:
NUM_REQ, 2, number of requester channels (1..4); channel 0 has highest priority at reset.
TIMEOUT, 0, waitrequest cycles before an abort with error; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset; one clock domain.
req_valid  in  NUM_REQ  per-channel request.
req_ready  out  NUM_REQ  one-hot grant pulse; the request is latched in that cycle.
req_addr  in  32*NUM_REQ  byte address, channel i in bits [32i+31:32i].
req_write  in  NUM_REQ  1 = store, 0 = load.
req_size  in  2*NUM_REQ  00 byte, 01 half, 10 word; 11 is illegal and is treated as an error.
req_signed  in  NUM_REQ  sign-extend load data.
req_wdata  in  32*NUM_REQ  store data, right-aligned.
resp_valid  out  NUM_REQ  one-cycle pulse to the granted channel.
resp_rdata  out  32  extended load data, valid with resp_valid.
resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid.
busy  out  1  high in any state other than IDLE.
address  out  32  word-aligned bus address ({addr[31:2],2'b00}).
read  out  1  Avalon read.
write  out  1  Avalon write.
waitrequest  in  1  Avalon stall.
byteenable  out  4  active lanes.
writedata  out  32  lane-steered store data.
readdata  in  32  valid in the cycle after the read is accepted.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, state is IDLE, and the round-robin pointer selects channel 0. A transaction in flight is dropped with no response.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any req_valid is set, grant one channel by round-robin starting after the last granted channel.
  - Pulse req_ready for that channel for one cycle and latch addr, write, size, signed and wdata.
  - Misaligned or illegal requests go directly to RESP with the error flag set and no bus cycle. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive read or write, address, byteenable and writedata, held stable while waitrequest=1.
  - An access is accepted in the first cycle with waitrequest=0; the next state is RESP.
  - If TIMEOUT>0 and waitrequest has been 1 for TIMEOUT consecutive ACCESS cycles: deassert read/write and go to RESP with the error flag set. This is a simulation/debug aid only.
- RESP:
  - Pulse resp_valid for the owning channel for one cycle.
  - resp_rdata is formed combinationally from readdata for loads; it is 0 for stores and errors.
  - Next state is IDLE.
- Latency: a request granted in cycle N with no wait states reaches the bus in N+1 and responds in N+2; the next grant is possible in N+3. Each waitrequest cycle adds one cycle.
- Lanes are little-endian:
  - Byte at k: byteenable=1<<k; writedata has the byte replicated on all lanes.
  - Half: byteenable is 0011 when addr[1]=0, else 1100; writedata has the half replicated.
  - Word: byteenable 1111.
- Loads select the addressed byte or half, then zero-extend, or sign-extend if req_signed.
- A req_valid deasserted before grant is simply not granted. Requests arriving while busy wait; they are never lost.
- busy=0 only in IDLE.

Test Plan:
- Word load at 0xBFC00000 with readdata=0x12345678 and no wait states -> read=1 in N+1; resp_valid and rdata=0x12345678 in N+2; byteenable=1111.
- Signed byte load at 0x103 with readdata=0x80FF0011 -> byteenable=1000, rdata=0xFFFFFF80. The same load unsigned -> rdata=0x00000080.
- Half store of 0xBEEF at 0x202 with waitrequest high for 3 cycles -> address 0x200, byteenable=1100, writedata=0xBEEFBEEF held for 4 cycles; resp_valid one cycle after acceptance.
- Both channels valid continuously -> grants alternate 0,1,0,1, with no bus cycle overlap.
- Word load at 0x6 -> no read asserted; resp_err=1 in N+1. With TIMEOUT=5 and waitrequest stuck at 1 -> read drops after 5 cycles and resp_err=1.
- reset driven low mid-ACCESS -> read, write and busy clear immediately without a clock; after release, channel 0 wins the first contested grant.

Source files
------------

// File: rtl/mips_bus_port.sv
// Avalon-MM master front-end for the multicycle MIPS core: round-robin requester
// arbitration, byte-lane steering, load extension, waitrequest stall and error reporting.
//
// state  | meaning
// IDLE   | no transaction owned; arbitrate and latch a request
// ACCESS | Avalon read/write driven, held while waitrequest is high
// RESP   | one-cycle response pulse to the owning channel
module mips_bus_port #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [2*NUM_REQ-1:0]   req_size,
  input  logic [NUM_REQ-1:0]     req_signed,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output logic [31:0]            address,
  output logic                   read,
  output logic                   write,
  input  logic                   waitrequest,
  output logic [3:0]             byteenable,
  output logic [31:0]            writedata,
  input  logic [31:0]            readdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW:0]   NREQ    = (IW+1)'(NUM_REQ);
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]          rr_ptr, gnt_off, gnt_idx, owner;
  logic [IW:0]            gnt_sum, ptr_sum;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic                   gnt_found;

  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_write, sel_signed, sel_bad;

  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic          write_q, signed_q, err_q;
  logic [TW-1:0] timer;
  logic          timeout;

  logic [3:0]  be_c;
  logic [31:0] wd_c, load_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Rotate the request vector so rr_ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_dbl   = {req_valid, req_valid} >> rr_ptr;
    gnt_found = |req_dbl[NUM_REQ-1:0];
    gnt_off   = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (req_dbl[j]) gnt_off = IW'(j);
    end
    gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
    if (gnt_sum >= NREQ) gnt_sum = gnt_sum - NREQ;
    gnt_idx = gnt_sum[IW-1:0];
    ptr_sum = {1'b0, gnt_idx} + (IW+1)'(1);
    if (ptr_sum >= NREQ) ptr_sum = ptr_sum - NREQ;
  end

  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_size   = '0;
    sel_write  = 1'b0;
    sel_signed = 1'b0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (gnt_idx == IW'(c)) begin
        sel_addr   = req_addr[32*c +: 32];
        sel_wdata  = req_wdata[32*c +: 32];
        sel_size   = req_size[2*c +: 2];
        sel_write  = req_write[c];
        sel_signed = req_signed[c];
      end
    end
    sel_bad = (sel_size == 2'b11) ||
              (sel_size == 2'b01 && sel_addr[0]) ||
              (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
  end

  assign timeout = (TIMEOUT > 0) && waitrequest && (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = sel_bad ? RESP : ACCESS;
      ACCESS:  if (!waitrequest || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      timer    <= '0;
    end else if (state == IDLE && gnt_found) begin
      rr_ptr   <= ptr_sum[IW-1:0];
      owner    <= gnt_idx;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      size_q   <= sel_size;
      write_q  <= sel_write;
      signed_q <= sel_signed;
      err_q    <= sel_bad;
      timer    <= TO_LOAD;
    end else if (state == ACCESS && waitrequest) begin
      if (timeout) err_q <= 1'b1;
      else         timer <= timer - TW'(1);
    end
  end

  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_q;
    case (size_q)
      2'b00: begin
        be_c = 4'b0001 << addr_q[1:0];
        wd_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    case (addr_q[1:0])
      2'b00:   rd_byte = readdata[7:0];
      2'b01:   rd_byte = readdata[15:8];
      2'b10:   rd_byte = readdata[23:16];
      default: rd_byte = readdata[31:24];
    endcase
    rd_half = addr_q[1] ? readdata[31:16] : readdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = readdata;
    endcase
  end

  // req_ready is gated by reset so a pending request is not acknowledged while held in reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = '0;
    writedata  = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (gnt_found && reset) req_ready = NUM_REQ'(1) << gnt_idx;
      end
      ACCESS: begin
        address    = {addr_q[31:2], 2'b00};
        read       = !write_q;
        write      = write_q;
        byteenable = be_c;
        writedata  = wd_c;
      end
      RESP: begin
        resp_valid = NUM_REQ'(1) << owner;
        resp_err   = err_q;
        resp_rdata = (err_q || write_q) ? 32'h0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_port.sv
// Bench for mips_bus_port (NUM_REQ=2, TIMEOUT=5): transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mips_bus_port;
  localparam int NR = 2;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, req_signed, resp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic        resp_err, busy, read, write, waitrequest;
  logic [3:0]  byteenable;

  mips_bus_port #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] lane_mask(input int nb);
    return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
  endfunction

  function automatic logic [3:0] f_be(input logic [31:0] a, input logic [1:0] s);
    int v;
    v = ((1 << nbytes(s)) - 1) << a[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] f_wd(input logic [31:0] d, input logic [1:0] s);
    int nb;
    logic [31:0] r;
    nb = nbytes(s);
    r = '0;
    for (int k = 0; k < 4/nb; k++) r = r | ((d & lane_mask(nb)) << (8*nb*k));
    return r;
  endfunction

  function automatic logic [31:0] f_ld(input logic [31:0] rd, input logic [31:0] a,
                                       input logic [1:0] s, input logic sg);
    int nb;
    logic [31:0] v;
    nb = nbytes(s);
    v = (rd >> (8*a[1:0])) & lane_mask(nb);
    if (sg && nb < 4 && v[8*nb-1]) v = v | ~lane_mask(nb);
    return v;
  endfunction

  function automatic logic f_bad(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  // reference model state
  int m_phase = 0, m_rr = 0, m_ch = 0, m_wcnt = 0, mc;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic        m_wr, m_sgn, m_err, m_found;
  logic [1:0]  e_ready, e_rv;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;
  logic        e_read, e_write, e_err, e_busy;

  // observations of the DUT for the directed checks
  int cyc = 0, g_cyc = 0, b_first = 0, b_last = 0, b_n = 0, r_cyc = 0;
  logic [31:0] o_addr, o_wd, o_rd;
  logic [3:0]  o_be;
  logic        o_err, o_stable;
  int gq[$];
  int gcq[$];

  always @(negedge clk) begin
    cyc++;
    if (req_ready != 2'b00) begin
      g_cyc = cyc; b_n = 0; o_stable = 1'b1;
      gq.push_back(req_ready[1] ? 1 : 0);
      gcq.push_back(cyc);
    end
    if (read || write) begin
      b_n++;
      if (b_n == 1) begin
        b_first = cyc; o_addr = address; o_be = byteenable; o_wd = writedata;
      end else if (address !== o_addr || byteenable !== o_be || writedata !== o_wd) begin
        o_stable = 1'b0;
      end
      b_last = cyc;
    end
    if (resp_valid != 2'b00) begin
      r_cyc = cyc; o_rd = resp_rdata; o_err = resp_err;
    end

    e_ready = '0; e_rv = '0; e_rd = '0; e_err = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_read = 1'b0; e_write = 1'b0; e_be = '0; e_wd = '0;
    if (!reset) begin
      m_phase = 0; m_rr = 0;
    end else begin
      case (m_phase)
        0: begin
          m_found = 1'b0;
          for (int k = 0; k < NR; k++) begin
            mc = (m_rr + k) % NR;
            if (!m_found && req_valid[mc]) begin
              m_found = 1'b1;
              m_ch    = mc;
            end
          end
          if (m_found) begin
            e_ready[m_ch] = 1'b1;
            m_addr  = req_addr[32*m_ch +: 32];
            m_wdata = req_wdata[32*m_ch +: 32];
            m_size  = req_size[2*m_ch +: 2];
            m_wr    = req_write[m_ch];
            m_sgn   = req_signed[m_ch];
            m_err   = f_bad(m_addr, m_size);
            m_phase = m_err ? 2 : 1;
            m_wcnt  = 0;
            m_rr    = (m_ch + 1) % NR;
          end
        end
        1: begin
          e_busy = 1'b1; e_read = !m_wr; e_write = m_wr;
          e_addr = m_addr & ~32'h3;
          e_be   = f_be(m_addr, m_size);
          e_wd   = f_wd(m_wdata, m_size);
          if (waitrequest) begin
            m_wcnt++;
            if (m_wcnt == TO) begin m_err = 1'b1; m_phase = 2; end
          end else begin
            m_phase = 2;
          end
        end
        default: begin
          e_busy = 1'b1; e_rv[m_ch] = 1'b1; e_err = m_err;
          e_rd = (m_err || m_wr) ? 32'h0 : f_ld(readdata, m_addr, m_size, m_sgn);
          m_phase = 0;
        end
      endcase
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
    chk("resp_valid", {30'd0, resp_valid}, {30'd0, e_rv});
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("address", address, e_addr);
    chk("read", {31'd0, read}, {31'd0, e_read});
    chk("write", {31'd0, write}, {31'd0, e_write});
    chk("byteenable", {28'd0, byteenable}, {28'd0, e_be});
    chk("writedata", writedata, e_wd);
  end

  task automatic do_req(input int ch, input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int nwait);
    logic ok;
    @(posedge clk); #1;
    req_addr[32*ch +: 32]  = a;
    req_wdata[32*ch +: 32] = wd;
    req_size[2*ch +: 2]    = sz;
    req_write[ch]          = w;
    req_signed[ch]         = sg;
    req_valid[ch]          = 1'b1;
    waitrequest            = (nwait > 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[ch]) begin ok = 1'b1; break; end
    end
    chk("grant_wait", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    if (nwait < 255) begin
      for (int i = 0; i < nwait; i++) begin @(posedge clk); #1; end
      waitrequest = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid[ch]) begin ok = 1'b1; break; end
    end
    chk("resp_wait", {31'd0, ok}, 32'd1);
    waitrequest = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    reset = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_size = '0;
    req_signed = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
    #2 reset = 1'b0;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b1;

    readdata = 32'h1234_5678;
    do_req(0, 32'hBFC0_0000, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    chk("t1_rdata", o_rd, 32'h1234_5678);
    chk("t1_bus_lat", b_first - g_cyc, 32'd1);
    chk("t1_resp_lat", r_cyc - g_cyc, 32'd2);
    chk("t1_be", {28'd0, o_be}, 32'hF);
    chk("t1_addr", o_addr, 32'hBFC0_0000);
    chk("t1_err", {31'd0, o_err}, 32'd0);

    readdata = 32'h80FF_0011;
    do_req(1, 32'h103, 1'b0, 2'b00, 1'b1, 32'h0, 0);
    chk("t2_be", {28'd0, o_be}, 32'h8);
    chk("t2_rdata_s", o_rd, 32'hFFFF_FF80);
    do_req(1, 32'h103, 1'b0, 2'b00, 1'b0, 32'h0, 0);
    chk("t2_rdata_u", o_rd, 32'h0000_0080);
    do_req(0, 32'h102, 1'b0, 2'b01, 1'b1, 32'h0, 0);
    chk("t2_half_s", o_rd, 32'hFFFF_80FF);

    do_req(0, 32'h202, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 3);
    chk("t3_addr", o_addr, 32'h200);
    chk("t3_be", {28'd0, o_be}, 32'hC);
    chk("t3_wd", o_wd, 32'hBEEF_BEEF);
    chk("t3_bus_cycles", b_n, 32'd4);
    chk("t3_stable", {31'd0, o_stable}, 32'd1);
    chk("t3_resp_after_accept", r_cyc - b_last, 32'd1);
    chk("t3_rdata", o_rd, 32'd0);

    do_req(1, 32'h1, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, 0);
    chk("t3b_be", {28'd0, o_be}, 32'h2);
    chk("t3b_wd", o_wd, 32'hA5A5_A5A5);

    do_req(1, 32'h6, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    chk("t4_no_bus", b_n, 32'd0);
    chk("t4_err", {31'd0, o_err}, 32'd1);
    chk("t4_resp_lat", r_cyc - g_cyc, 32'd1);
    do_req(0, 32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 0);
    chk("t4_illegal_err", {31'd0, o_err}, 32'd1);
    chk("t4_illegal_no_bus", b_n, 32'd0);

    do_req(0, 32'h40, 1'b0, 2'b10, 1'b0, 32'h0, 255);
    chk("t5_read_cycles", b_n, 32'd5);
    chk("t5_err", {31'd0, o_err}, 32'd1);
    chk("t5_rdata", o_rd, 32'd0);
    chk("t5_resp_after_drop", r_cyc - b_last, 32'd1);

    @(posedge clk); #1;
    req_addr[31:0] = 32'h100; req_write[0] = 1'b0; req_size[1:0] = 2'b10;
    req_signed[0] = 1'b0; req_valid[0] = 1'b1; waitrequest = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1'b1; break; end
    end
    chk("t6_grant_wait", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1 chk("t6_read_before", {31'd0, read}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_read_cleared", {31'd0, read}, 32'd0);
    chk("t6_write_cleared", {31'd0, write}, 32'd0);
    chk("t6_busy_cleared", {31'd0, busy}, 32'd0);
    waitrequest = 1'b0;
    req_addr = {32'h21, 32'h10}; req_size = {2'b00, 2'b10};
    req_write = 2'b00; req_signed = 2'b00; readdata = 32'hCAFE_F00D;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    gq.delete(); gcq.delete();
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (5) @(posedge clk);
    chk("t6_grant_count", gq.size(), 32'd4);
    if (gq.size() == 4) begin
      chk("t6_grant0", gq[0], 32'd0);
      chk("t6_grant1", gq[1], 32'd1);
      chk("t6_grant2", gq[2], 32'd0);
      chk("t6_grant3", gq[3], 32'd1);
      for (int i = 1; i < 4; i++) chk("t6_grant_spacing", gcq[i] - gcq[i-1], 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
